// File: rtl/pq_modarith_pipe.sv
// Three-stage modular arithmetic pipeline for lattice-crypto coefficients.
// Each lane performs MUL / MAC / ADD / SUB / CLR modulo Q, using Barrett
// reduction for products and a per-lane accumulator for MAC/CLR.
// All stages advance together under a single enable, so a stalled output
// freezes the whole pipe and no beat can touch its accumulator twice.
module pq_modarith_pipe #(
    parameter int Q     = 3329,
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               op_i,
    input  logic [LANES*WIDTH-1:0]   a_i,
    input  logic [LANES*WIDTH-1:0]   b_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [LANES*WIDTH-1:0]   result_o,
    output logic [LANES-1:0]         err_o
);

    localparam int K  = $clog2(Q);
    // Product p*MU: p < 2^(2W), MU < 2^(K+1) because Q > 2^(K-1).
    localparam int PW = 2*WIDTH + K + 1;
    localparam logic [PW-1:0]      MU = PW'((64'd1 << (2*K)) / 64'(Q));
    localparam logic [WIDTH-1:0]   QW = WIDTH'(Q);
    localparam logic [WIDTH:0]     QS = (WIDTH+1)'(Q);
    localparam logic [2*WIDTH-1:0] QP = (2*WIDTH)'(Q);

    localparam logic [2:0] OP_MUL = 3'd0;
    localparam logic [2:0] OP_MAC = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;

    // Barrett reduction of a double-width product; the quotient estimate is
    // at most two short, so two conditional subtractions always suffice.
    function automatic logic [WIDTH-1:0] barrett(input logic [2*WIDTH-1:0] p);
        logic [PW-1:0]      prod;
        logic [2*WIDTH-1:0] t;
        logic [2*WIDTH-1:0] r;
        prod = PW'(p) * MU;
        t    = (2*WIDTH)'(prod >> (2*K));
        r    = p - t * QP;
        if (r >= QP) r = r - QP;
        if (r >= QP) r = r - QP;
        return WIDTH'(r);
    endfunction

    // Sum of two residues, folded back below Q.
    function automatic logic [WIDTH-1:0] modadd(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QS) s = s - QS;
        return WIDTH'(s);
    endfunction

    logic en;
    assign en      = !valid_o | ready_i;
    assign ready_o = en;

    logic                 v1;
    logic [2:0]           op1;
    logic [WIDTH-1:0]     a1 [LANES];
    logic [WIDTH-1:0]     b1 [LANES];

    logic                 v2;
    logic [2:0]           op2;
    logic [2*WIDTH-1:0]   p2 [LANES];
    logic [LANES-1:0]     e2;
    logic [2*WIDTH-1:0]   p2_d [LANES];
    logic [LANES-1:0]     e2_d;

    logic [WIDTH-1:0]     acc [LANES];
    logic [WIDTH-1:0]     res_d [LANES];
    logic [WIDTH-1:0]     acc_d [LANES];
    logic [LANES-1:0]     err_d;

    // S1: capture opcode and per-lane operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            op1 <= '0;
            for (int n = 0; n < LANES; n++) begin
                a1[n] <= '0;
                b1[n] <= '0;
            end
        end else if (en) begin
            v1  <= valid_i;
            op1 <= op_i;
            for (int n = 0; n < LANES; n++) begin
                a1[n] <= a_i[n*WIDTH +: WIDTH];
                b1[n] <= b_i[n*WIDTH +: WIDTH];
            end
        end
    end

    // S2 datapath: full product for MUL/MAC, pre-sum or wrapped difference
    // for ADD/SUB, and operand range / reserved-op error detection.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            p2_d[n] = '0;
            e2_d[n] = 1'b0;
            case (op1)
                OP_MUL, OP_MAC: begin
                    p2_d[n] = (2*WIDTH)'(a1[n]) * (2*WIDTH)'(b1[n]);
                    e2_d[n] = (a1[n] >= QW) || (b1[n] >= QW);
                end
                OP_ADD: begin
                    p2_d[n] = (2*WIDTH)'(a1[n]) + (2*WIDTH)'(b1[n]);
                    e2_d[n] = (a1[n] >= QW) || (b1[n] >= QW);
                end
                OP_SUB: begin
                    if (a1[n] >= b1[n])
                        p2_d[n] = (2*WIDTH)'(a1[n] - b1[n]);
                    else
                        p2_d[n] = (2*WIDTH)'(a1[n]) + QP - (2*WIDTH)'(b1[n]);
                    e2_d[n] = (a1[n] >= QW) || (b1[n] >= QW);
                end
                OP_CLR: ;
                default: e2_d[n] = 1'b1;
            endcase
        end
    end

    // S2: register product / pre-sum and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            op2 <= '0;
            e2  <= '0;
            for (int n = 0; n < LANES; n++) p2[n] <= '0;
        end else if (en) begin
            v2  <= v1;
            op2 <= op1;
            e2  <= e2_d;
            for (int n = 0; n < LANES; n++) p2[n] <= p2_d[n];
        end
    end

    // S3 datapath: final reduction and accumulator read-modify-write.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            res_d[n] = '0;
            err_d[n] = 1'b0;
            acc_d[n] = acc[n];
            if (e2[n]) begin
                err_d[n] = 1'b1;
            end else begin
                case (op2)
                    OP_MUL: res_d[n] = barrett(p2[n]);
                    OP_MAC: begin
                        res_d[n] = modadd(barrett(p2[n]), acc[n]);
                        acc_d[n] = res_d[n];
                    end
                    OP_ADD: res_d[n] = (p2[n] >= QP) ? WIDTH'(p2[n] - QP)
                                                     : WIDTH'(p2[n]);
                    OP_SUB: res_d[n] = WIDTH'(p2[n]);
                    OP_CLR: begin
                        res_d[n] = acc[n];
                        acc_d[n] = '0;
                    end
                    default: err_d[n] = 1'b1;
                endcase
            end
        end
    end

    // S3: output register and accumulators, updated only by a real beat
    // moving in, which happens exactly once per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            err_o    <= '0;
            for (int n = 0; n < LANES; n++) acc[n] <= '0;
        end else if (en) begin
            valid_o <= v2;
            if (v2) begin
                err_o <= err_d;
                for (int n = 0; n < LANES; n++) begin
                    result_o[n*WIDTH +: WIDTH] <= res_d[n];
                    acc[n]                     <= acc_d[n];
                end
            end
        end
    end

endmodule

// File: tb/tb_pq_modarith_pipe.sv
// Scoreboard bench for pq_modarith_pipe with two lanes at Q=3329.
module tb_pq_modarith_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [1:0]  err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];

    pq_modarith_pipe #(.Q(3329), .WIDTH(16), .LANES(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Issue one beat and, once accepted, record its expected result.
    task automatic send(input logic [2:0] op, input int a0, input int b0,
                        input int a1, input int b1, input int r0, input int r1,
                        input logic [1:0] e, input bit push, input bit lat);
        exp_t x;
        int   k;
        op_i    = op;
        a_i     = {16'(a1), 16'(a0)};
        b_i     = {16'(b1), 16'(b0)};
        valid_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready_o && k < 100);
        if (!ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: ready_o stuck at 0 after %0d cycles", k);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        if (push) begin
            x.res = {16'(r1), 16'(r0)};
            x.err = e;
            x.cyc = cyc;
            x.lat = lat;
            exp_q.push_back(x);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] hold_res;
    logic [1:0]  hold_err;
    bit          stall_prev = 1'b0;

    // Monitor: pop and compare on every transfer; verify hold during stalls.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (valid_o && ready_i) begin
            stall_prev = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got res=%0h err=%b, want none", result_o, err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (result_o !== e.res || err_o !== e.err) begin
                    failures++;
                    $display("FAIL result: got res=%0h err=%b, want res=%0h err=%b",
                             result_o, err_o, e.res, e.err);
                end
                if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end else if (valid_o && !ready_i) begin
            chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
            if (stall_prev) begin
                chk("stall_hold_res", result_o, hold_res);
                chk("stall_hold_err", {30'd0, err_o}, {30'd0, hold_err});
            end
            hold_res   = result_o;
            hold_err   = err_o;
            stall_prev = 1'b1;
        end
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_i    = 3'd0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_result_o", result_o, 32'd0);
        chk("rst_err_o", {30'd0, err_o}, 32'd0);
        chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // MUL corner with latency check
        send(3'd0, 3328, 3328, 100, 200, 1, 26, 2'b00, 1, 1);
        drain();

        // CLR / MAC chain back-to-back
        send(3'd4, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        send(3'd1, 2, 3, 10, 10, 6, 100, 2'b00, 1, 0);
        send(3'd1, 3328, 1, 3000, 3000, 5, 1813, 2'b00, 1, 0);
        send(3'd4, 0, 0, 0, 0, 5, 1813, 2'b00, 1, 0);
        send(3'd4, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);

        // ADD / SUB including wrap boundaries
        send(3'd2, 3000, 400, 1, 2, 71, 3, 2'b00, 1, 0);
        send(3'd3, 5, 10, 3328, 0, 3324, 3328, 2'b00, 1, 0);
        send(3'd3, 7, 7, 0, 3328, 0, 1, 2'b00, 1, 0);
        send(3'd2, 3328, 1, 3328, 3328, 0, 3327, 2'b00, 1, 0);

        // Illegal operands on one lane only
        send(3'd1, 7, 1, 1, 1, 7, 1, 2'b00, 1, 0);
        send(3'd1, 3329, 1, 4, 5, 0, 21, 2'b01, 1, 0);
        send(3'd2, 1, 1, 0, 65535, 2, 0, 2'b10, 1, 0);
        send(3'd4, 0, 0, 0, 0, 7, 21, 2'b00, 1, 0);

        // Reserved opcodes leave accumulators alone
        send(3'd1, 2, 2, 2, 2, 4, 4, 2'b00, 1, 0);
        send(3'd5, 1, 1, 1, 1, 0, 0, 2'b11, 1, 0);
        send(3'd7, 9, 9, 9, 9, 0, 0, 2'b11, 1, 0);
        send(3'd4, 0, 0, 0, 0, 4, 4, 2'b00, 1, 0);
        drain();

        // MAC stream with a 4-cycle downstream stall in the middle
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int s0, s1;
                    s0 = (i + 1) * (i + 2);
                    s1 = 13 * (i + 1) * (i + 2) / 2;
                    send(3'd1, i + 1, 2, 100 * (i + 1), 100, s0, s1, 2'b00, 1, 0);
                end
                send(3'd4, 0, 0, 0, 0, 42, 273, 2'b00, 1, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                ready_i = 1'b0;
                repeat (4) @(posedge clk);
                #2;
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset with three MAC beats in flight
        send(3'd1, 5, 5, 6, 6, 0, 0, 2'b00, 0, 0);
        send(3'd1, 5, 5, 6, 6, 0, 0, 2'b00, 0, 0);
        send(3'd1, 5, 5, 6, 6, 0, 0, 2'b00, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("post_rst_ready_o", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        send(3'd1, 1, 1, 1, 1, 1, 1, 2'b00, 1, 0);
        send(3'd4, 0, 0, 0, 0, 1, 1, 2'b00, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pq_modarith_pipe.md
PQ_MODARITH_PIPE -- requirements
Module: pq_modarith_pipe

Interface
REQ-001 Parameter Q, default 3329: modulus, odd, 3 <= Q < 2**WIDTH.
REQ-002 Parameter WIDTH, default 16: coefficient width in bits per lane.
REQ-003 Parameter LANES, default 1: number of independent coefficient lanes.
REQ-004 Derived constants: K = $clog2(Q); MU = floor(4**K / Q).
REQ-005 clk  in  1  clock, rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 valid_i  in  1  input beat valid.
REQ-008 ready_o  out  1  input beat accepted when valid_i & ready_o.
REQ-009 op_i  in  3  operation: 000 MUL, 001 MAC, 010 ADD, 011 SUB, 100 CLR; other codes reserved.
REQ-010 a_i  in  LANES*WIDTH  operand A; lane n occupies bits [n*WIDTH +: WIDTH].
REQ-011 b_i  in  LANES*WIDTH  operand B; same lane packing as a_i.
REQ-012 valid_o  out  1  result valid.
REQ-013 ready_i  in  1  downstream accepts result when valid_o & ready_i.
REQ-014 result_o  out  LANES*WIDTH  per-lane result; lane packing as a_i.
REQ-015 err_o  out  LANES  per-lane illegal-operand flag, qualified by valid_o.

Function
REQ-016 Pipeline SHALL have 3 register stages: S1 operand/op capture, S2 product/pre-sum, S3 reduction/accumulate into output register.
REQ-017 Global enable en = !valid_o | ready_i; all stages SHALL advance only when en=1.
REQ-018 ready_o SHALL equal en; combinational from valid_o and ready_i only.
REQ-019 Latency: beat accepted in cycle t SHALL appear on valid_o/result_o in cycle t+3 if en stays high; one result per cycle sustained.
REQ-020 While valid_o=1 and ready_i=0, result_o, err_o and valid_o SHALL hold stable, and no stage or accumulator SHALL change.
REQ-021 Each lane SHALL hold a WIDTH-bit accumulator acc[n], always < Q.
REQ-022 MUL: p = a*b (2*WIDTH bits); t = (p*MU) >> 2K; r = p - t*Q; subtract Q while r >= Q (at most 2 subtractions); result = r.
REQ-023 MAC: r as in MUL; s = r + acc[n]; if s >= Q then s -= Q; result = s; acc[n] <= s.
REQ-024 ADD: s = a + b (WIDTH+1 bits); if s >= Q then s -= Q; result = s.
REQ-025 SUB: d = a - b; if negative then d += Q; result = d.
REQ-026 CLR: result = acc[n]; acc[n] <= 0; operands ignored, err_o = 0.
REQ-027 Accumulator SHALL be read and written only in S3, on the beat moving into the output register, so back-to-back MACs chain with no bubble.
REQ-028 Illegal operand (a >= Q or b >= Q on MUL/MAC/ADD/SUB): lane result = 0, err_o[n] = 1, acc[n] unchanged; other lanes unaffected.
REQ-029 Reserved op code: all lanes result = 0, err_o = all ones, accumulators unchanged.
REQ-030 Lanes SHALL be fully independent; no cross-lane carry.
REQ-031 A beat SHALL update acc exactly once, regardless of stall duration.

Reset
REQ-032 On rst=1 at a rising edge: all stage valids, valid_o = 0, result_o = 0, err_o = 0, and every acc[n] = 0.
REQ-033 rst SHALL take priority over en; in-flight beats SHALL be discarded with no accumulator update.
REQ-034 ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 MUL, Q=3329, a=3328, b=3328, ready_i=1 -> result 1, err 0, valid_o exactly 3 cycles after acceptance.
REQ-036 Back-to-back CLR, MAC(2,3), MAC(3328,1), CLR -> results (prior acc), 6, 5, 5; acc = 0 afterwards.
REQ-037 ADD(3000,400) -> 71; SUB(5,10) -> 3324; SUB(7,7) -> 0.
REQ-038 MAC stream with ready_i held low 4 cycles mid-stream -> ready_o low, outputs stable, final acc equals the single-update sum.
REQ-039 LANES=2, lane 0 a=3329, lane 1 valid MAC -> lane 0 result 0, err 1, acc0 unchanged; lane 1 correct.
REQ-040 rst asserted with 3 beats in flight -> next cycle valid_o = 0, all acc = 0; a MAC(1,1) afterwards returns 1.
